// File: rtl/gf2_div_pkg.sv
// Shared widths, counter sizes and FSM state encoding for the bit-serial GF(2)[x] divider.
package gf2_div_pkg;

  localparam int N     = 283;
  localparam int M     = 2 * N;
  localparam int IDX_W = $clog2(N);
  localparam int J_W   = $clog2(M);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEG  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/gf2_div_step.sv
// One long-division iteration: shift in a dividend bit and conditionally cancel the divisor.
module gf2_div_step
  import gf2_div_pkg::*;
(
  input  logic [N-2:0]     i_rem,
  input  logic             i_bit,
  input  logic [N-1:0]     i_b,
  input  logic [IDX_W-1:0] i_deg,
  output logic [N-1:0]     o_rem,
  output logic             o_qbit
);

  logic [N-1:0] w_t;

  // The incoming remainder has degree below i_deg, so its top bit is known zero and is not carried.
  assign w_t    = {i_rem, i_bit};
  assign o_qbit = w_t[i_deg];
  assign o_rem  = o_qbit ? (w_t ^ i_b) : w_t;

endmodule

// File: rtl/gf2_poly_divider.sv
// Bit-serial GF(2)[x] long divider: a = q*b ^ r with deg(r) < deg(b), one dividend bit per cycle.
//   state   | meaning
//   ST_IDLE | waiting for start; results hold
//   ST_DEG  | scanning b from the top for its degree
//   ST_DIV  | one dividend bit per cycle, MSB first
//   ST_FIN  | done pulse; results valid
module gf2_poly_divider
  import gf2_div_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] q,
  output logic [N-1:0] r,
  output logic         div_by_zero
);

  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N - 1);
  localparam logic [J_W-1:0]   J_TOP   = J_W'(M - 1);

  state_t           r_state,  w_state_nxt;
  logic [M-1:0]     r_a,      w_a_nxt;
  logic [N-1:0]     r_b,      w_b_nxt;
  logic [N-2:0]     r_rem,    w_rem_nxt;
  logic [M-1:0]     r_quo,    w_quo_nxt;
  logic [IDX_W-1:0] r_idx,    w_idx_nxt;
  logic [IDX_W-1:0] r_deg,    w_deg_nxt;
  logic [J_W-1:0]   r_j,      w_j_nxt;
  logic [M-1:0]     r_q_out,  w_q_out_nxt;
  logic [N-1:0]     r_r_out,  w_r_out_nxt;
  logic             r_dbz,    w_dbz_nxt;
  logic             r_done,   w_done_nxt;

  logic [N-1:0]     w_step_rem;
  logic             w_step_qbit;

  gf2_div_step u_step (
    .i_rem  (r_rem),
    .i_bit  (r_a[r_j]),
    .i_b    (r_b),
    .i_deg  (r_deg),
    .o_rem  (w_step_rem),
    .o_qbit (w_step_qbit)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_rem_nxt   = r_rem;
    w_quo_nxt   = r_quo;
    w_idx_nxt   = r_idx;
    w_deg_nxt   = r_deg;
    w_j_nxt     = r_j;
    w_q_out_nxt = r_q_out;
    w_r_out_nxt = r_r_out;
    w_dbz_nxt   = r_dbz;
    w_done_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_a_nxt     = a;
          w_b_nxt     = b;
          w_rem_nxt   = '0;
          w_quo_nxt   = '0;
          w_idx_nxt   = IDX_TOP;
          w_dbz_nxt   = 1'b0;
          w_state_nxt = ST_DEG;
        end
      end

      ST_DEG: begin
        if (r_b[r_idx]) begin
          w_deg_nxt   = r_idx;
          w_j_nxt     = J_TOP;
          w_state_nxt = ST_DIV;
        end else if (r_idx == '0) begin
          w_q_out_nxt = '0;
          w_r_out_nxt = '0;
          w_dbz_nxt   = 1'b1;
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_FIN;
        end else begin
          w_idx_nxt = r_idx - 1'b1;
        end
      end

      ST_DIV: begin
        // Bit j of the quotient is produced while dividend bit j is consumed.
        w_rem_nxt        = w_step_rem[N-2:0];
        w_quo_nxt[r_j]   = w_step_qbit;
        if (r_j == '0) begin
          // Results are loaded on the way into ST_FIN so they are valid with the done pulse.
          w_q_out_nxt = w_quo_nxt;
          w_r_out_nxt = w_step_rem;
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_FIN;
        end else begin
          w_j_nxt = r_j - 1'b1;
        end
      end

      ST_FIN: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_idx   <= '0;
      r_deg   <= '0;
      r_j     <= '0;
      r_q_out <= '0;
      r_r_out <= '0;
      r_dbz   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_rem   <= w_rem_nxt;
      r_quo   <= w_quo_nxt;
      r_idx   <= w_idx_nxt;
      r_deg   <= w_deg_nxt;
      r_j     <= w_j_nxt;
      r_q_out <= w_q_out_nxt;
      r_r_out <= w_r_out_nxt;
      r_dbz   <= w_dbz_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign q           = r_q_out;
  assign r           = r_r_out;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_gf2_poly_divider.sv
// Randomized self-checking bench for gf2_poly_divider against a textbook polynomial-division model.
module tb_gf2_poly_divider;
  import gf2_div_pkg::*;

  logic         clk;
  logic         rst;
  logic         start;
  logic [M-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [M-1:0] q;
  logic [N-1:0] r;
  logic         div_by_zero;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  // Reference-model state: acceptance window and held result registers.
  bit           m_active = 1'b0;
  int           m_t      = 0;
  int           m_done   = 0;
  logic [M-1:0] m_q      = '0;
  logic [N-1:0] m_r      = '0;
  logic         m_dbz    = 1'b0;
  logic [M-1:0] e_q;
  logic [N-1:0] e_r;
  logic         e_dbz;

  gf2_poly_divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .q           (q),
    .r           (r),
    .div_by_zero (div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [M-1:0] act, input logic [M-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic int poly_deg(input logic [N-1:0] p);
    for (int i = N - 1; i >= 0; i--) if (p[i]) return i;
    return -1;
  endfunction

  function automatic int exp_lat(input logic [N-1:0] ib);
    int d;
    d = poly_deg(ib);
    return (d < 0) ? 284 : 850 - d;
  endfunction

  function automatic void model_div(input logic [M-1:0] ia, input logic [N-1:0] ib,
                                    output logic [M-1:0] oq, output logic [N-1:0] orem,
                                    output logic odbz);
    logic [M-1:0] rem;
    logic [M-1:0] bw;
    int db;
    oq   = '0;
    orem = '0;
    db   = poly_deg(ib);
    odbz = (db < 0);
    if (db < 0) return;
    rem = ia;
    bw  = M'(ib);
    for (int i = M - 1; i >= db; i--) begin
      if (rem[i]) begin
        rem       = rem ^ (bw << (i - db));
        oq[i - db] = 1'b1;
      end
    end
    orem = rem[N-1:0];
  endfunction

  function automatic logic [M-1:0] clmul(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [M-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) if (y[i]) p = p ^ (M'(x) << i);
    return p;
  endfunction

  function automatic logic [M-1:0] rand_m();
    logic [575:0] t;
    for (int i = 0; i < 18; i++) t[i*32 +: 32] = $urandom;
    return t[M-1:0];
  endfunction

  function automatic logic [N-1:0] rand_n();
    logic [287:0] t;
    for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom;
    return t[N-1:0];
  endfunction

  // Model: decides acceptance from the busy window and schedules the expected done cycle.
  initial begin
    int nc;
    forever begin
      @(posedge clk);
      nc = cyc + 1;
      if (rst) begin
        m_active = 1'b0;
        m_q      = '0;
        m_r      = '0;
        m_dbz    = 1'b0;
      end else begin
        if (start && !(m_active && cyc >= m_t + 1 && cyc <= m_done)) begin
          m_active = 1'b1;
          m_t      = cyc;
          model_div(a, b, e_q, e_r, e_dbz);
          m_done   = cyc + exp_lat(b);
        end
        if (m_active && nc == m_t + 1) m_dbz = 1'b0;
        if (m_active && nc == m_done) begin
          m_q   = e_q;
          m_r   = e_r;
          m_dbz = e_dbz;
        end
      end
      cyc = nc;
    end
  end

  // Compare process: every cycle, all outputs against the model.
  initial begin
    logic exp_busy;
    logic exp_done;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        exp_busy = m_active && (cyc >= m_t + 1) && (cyc <= m_done);
        exp_done = m_active && (cyc == m_done);
        chk("mon_busy", M'(busy), M'(exp_busy));
        chk("mon_done", M'(done), M'(exp_done));
        chk("mon_q", q, m_q);
        chk("mon_r", M'(r), M'(m_r));
        chk("mon_dbz", M'(div_by_zero), M'(m_dbz));
      end
    end
  end

  task automatic wait_done(input string nm, output int td);
    td = -1;
    for (int k = 0; k < 900; k++) begin
      if (done === 1'b1) begin
        td = cyc;
        break;
      end
      @(negedge clk);
    end
    chk({nm, "_done_seen"}, M'(td >= 0), M'(1));
  endtask

  task automatic run_op(input logic [M-1:0] ia, input logic [N-1:0] ib, input string nm,
                        output int lat);
    int t0, td;
    logic [M-1:0] mq;
    logic [N-1:0] mr;
    logic         mz;
    @(negedge clk);
    a = ia;
    b = ib;
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    wait_done(nm, td);
    lat = td - t0;
    model_div(ia, ib, mq, mr, mz);
    chk({nm, "_lat"}, M'(lat), M'(exp_lat(ib)));
    chk({nm, "_q"}, q, mq);
    chk({nm, "_r"}, M'(r), M'(mr));
  endtask

  initial begin
    int lat, t0, td;
    logic [M-1:0] ra, rq;
    logic [N-1:0] rb, rp, rr;
    logic         rz;

    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, t0, td;
    logic [M-1:0] ra, rq;
    logic [N-1:0] rb, rp, rr;
    logic         rz;

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;

    // Pin the model with hand-computed results.
    model_div(M'(566'h15), N'(283'h3), rq, rr, rz);
    chk("model_small_q", rq, M'(12));
    chk("model_small_r", M'(rr), M'(1));
    ra = rand_m();
    model_div(ra, N'(283'h1), rq, rr, rz);
    chk("model_unit_q", rq, ra);
    rp = rand_n();
    rb = rand_n();
    rb[N-1] = 1'b1;
    model_div(clmul(rp, rb), rb, rq, rr, rz);
    chk("model_rt_q", rq, M'(rp));
    model_div('1, '0, rq, rr, rz);
    chk("model_zero_flag", M'(rz), M'(1));

    repeat (3) @(negedge clk);
    chk("rst_busy", M'(busy), M'(0));
    chk("rst_done", M'(done), M'(0));
    chk("rst_q", q, M'(0));
    chk("rst_r", M'(r), M'(0));
    chk("rst_dbz", M'(div_by_zero), M'(0));
    rst = 1'b0;
    mon_en = 1'b1;

    run_op(M'(566'h15), N'(283'h3), "small", lat);
    chk("small_lat_lit", M'(lat), M'(849));
    chk("small_q_lit", q, M'(12));
    chk("small_r_lit", M'(r), M'(1));
    chk("small_dbz_lit", M'(div_by_zero), M'(0));

    ra = rand_m();
    run_op(ra, N'(283'h1), "unit", lat);
    chk("unit_lat_lit", M'(lat), M'(850));
    chk("unit_q_lit", q, ra);
    chk("unit_r_lit", M'(r), M'(0));

    run_op('1, '0, "zero", lat);
    chk("zero_lat_lit", M'(lat), M'(284));
    chk("zero_dbz_lit", M'(div_by_zero), M'(1));
    chk("zero_q_lit", q, M'(0));
    chk("zero_r_lit", M'(r), M'(0));

    for (int n = 0; n < 40; n++) begin
      rp = rand_n();
      rb = rand_n();
      rb[N-1] = 1'b1;
      rr = rand_n();
      rr[N-1] = 1'b0;
      run_op(clmul(rp, rb) ^ M'(rr), rb, "rt", lat);
      chk("rt_lat_lit", M'(lat), M'(568));
      chk("rt_q_p", q, M'(rp));
      chk("rt_r_rprime", M'(r), M'(rr));
    end

    for (int n = 0; n < 10; n++) begin
      rb = rand_n() >> $urandom_range(0, N - 1);
      if (rb == '0) rb = N'(283'h1);
      run_op(rand_m(), rb, "rand", lat);
    end

    // Protocol: starts while busy and in the done cycle are ignored; done+1 is accepted.
    @(negedge clk);
    a = M'(566'h15);
    b = N'(283'h3);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 10) @(negedge clk);
    a = rand_m();
    b = rand_n();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("proto", td);
    chk("proto_lat", M'(td - t0), M'(849));
    chk("proto_q", q, M'(12));
    chk("proto_r", M'(r), M'(1));
    a = rand_m();
    b = rand_n();
    start = 1'b1;
    @(negedge clk);
    chk("proto_busy_d1", M'(busy), M'(0));
    ra = rand_m();
    rb = N'(283'h5);
    a = ra;
    b = rb;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("proto_busy_d2", M'(busy), M'(1));
    wait_done("proto2", td);
    model_div(ra, rb, rq, rr, rz);
    chk("proto2_lat", M'(td - t0), M'(848));
    chk("proto2_q", q, rq);
    chk("proto2_r", M'(r), M'(rr));

    // Reset in the middle of DIV.
    @(negedge clk);
    a = rand_m();
    b = N'(283'h3);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 300) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", M'(busy), M'(0));
    chk("midrst_q", q, M'(0));
    chk("midrst_r", M'(r), M'(0));
    chk("midrst_done", M'(done), M'(0));
    repeat (600) @(negedge clk);
    ra = rand_m();
    run_op(ra, N'(283'h3), "postrst", lat);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
